// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and framing constants for the UART receiver.
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;
    localparam int DATA_BITS = 8;
    localparam logic PARITY_EVEN = 1'b0;
endpackage

// File: rtl/uart_rx_fifo_feeder_sync.sv
// rx_sync: multi-flop metastability synchroniser with a configurable reset value.
module rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {STAGES{RST_VAL}};
        else        sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// uart_rx_fifo_feeder: 8N1 UART receiver that writes each good byte into a byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data bit 7 and stop.
module uart_rx_fifo_feeder
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    input  logic       full_i,
    output logic       wr_o,
    output logic [7:0] din_o,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);

    rx_state_t              state_q;
    logic [BW-1:0]          baud_q;
    logic [2:0]             bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [7:0]             din_q;
    logic                   wr_q, frame_err_q, overrun_q, parity_err_q;
    logic                   rx_s;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q;
`endif

    rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            din_q        <= '0;
            wr_q         <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            wr_q         <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
            case (state_q)
                IDLE: if (!rx_s) begin
                    state_q <= START;
                    baud_q  <= '0;
                end
                START: if (baud_q == HALF_M1) begin
                    baud_q  <= '0;
                    bit_q   <= '0;
                    state_q <= rx_s ? IDLE : DATA;
                end else baud_q <= baud_q + 1'b1;
                DATA: if (baud_q == FULL_M1) begin
                    baud_q  <= '0;
                    shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_q == 3'(DATA_BITS - 1)) state_q <= PARITY;
`else
                    if (bit_q == 3'(DATA_BITS - 1)) state_q <= STOP;
`endif
                end else baud_q <= baud_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                PARITY: if (baud_q == FULL_M1) begin
                    baud_q    <= '0;
                    par_bad_q <= (^shift_q ^ rx_s) != PARITY_EVEN;
                    state_q   <= STOP;
                end else baud_q <= baud_q + 1'b1;
`endif
                // Error priority at the decision edge: framing, then parity, then overrun.
                STOP: if (baud_q == FULL_M1) begin
                    baud_q <= '0;
                    if (!rx_s) begin
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_HIGH;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) begin
                        parity_err_q <= 1'b1;
                        state_q      <= IDLE;
                    end
`endif
                    else if (full_i) begin
                        overrun_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        din_q   <= shift_q;
                        wr_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                end else baud_q <= baud_q + 1'b1;
                WAIT_HIGH: if (rx_s) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_o        = wr_q;
    assign din_o       = din_q;
    assign busy_o      = state_q != IDLE;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// tb_uart_rx_fifo_feeder: drives 8N1 frames into the receiver with a 16-deep FIFO model on the write side.
module tb_uart_rx_fifo_feeder;
    localparam int CPB  = 16;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NB     = 10;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NB     = 9;
`endif
    // Decision edge counted from the rx pin fall: synchroniser, one IDLE detect edge, then half + NB bits.
    localparam int LAT = SYNC + 1 + CPB / 2 + NB * CPB;

    logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, full = 1'b0;
    logic       wr, busy, frame_err, overrun, parity_err;
    logic [7:0] din;

    int tests, fails, cyc, n_wr, n_fe, n_ov, n_pe, consec, last_wr_cyc;
    logic [7:0] last_din;
    bit prev_wr;
    logic [7:0] fifo_q[$];
    logic [7:0] model_q[$];

    uart_rx_fifo_feeder #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx),
        .full_i       (full),
        .wr_o         (wr),
        .din_o        (din),
        .busy_o       (busy),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun),
        .parity_err_o (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr) begin
            n_wr++;
            last_din    = din;
            last_wr_cyc = cyc;
            if (fifo_q.size() < 16) fifo_q.push_back(din);
            if (prev_wr) consec++;
        end
        prev_wr = wr;
        if (frame_err)  n_fe++;
        if (overrun)    n_ov++;
        if (parity_err) n_pe++;
        full = fifo_q.size() >= 16;
    end

    task automatic send_frame(input logic [7:0] b, input int stop_low, input bit par);
        int c0, w0, f0, o0, p0;
        bit e_fe, e_pe, e_ov, e_wr;
        c0 = cyc; w0 = n_wr; f0 = n_fe; o0 = n_ov; p0 = n_pe;
        e_fe = stop_low > 0;
        e_pe = PAR_EN && !e_fe && (par != ^b);
        e_ov = !e_fe && !e_pe && model_q.size() >= 16;
        e_wr = !e_fe && !e_pe && !e_ov;
        if (e_wr) model_q.push_back(b);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (PAR_EN) begin
            rx = par;
            repeat (CPB) @(negedge clk);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            repeat (CPB * stop_low) @(negedge clk);
            tests++;
            if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_break: got %b want 1", busy); end
        end
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        tests++;
        if (n_wr - w0 !== int'(e_wr)) begin fails++; $display("FAIL wr_count byte %h: got %0d want %0d", b, n_wr - w0, e_wr); end
        tests++;
        if (n_fe - f0 !== int'(e_fe)) begin fails++; $display("FAIL frame_err byte %h: got %0d want %0d", b, n_fe - f0, e_fe); end
        tests++;
        if (n_ov - o0 !== int'(e_ov)) begin fails++; $display("FAIL overrun byte %h: got %0d want %0d", b, n_ov - o0, e_ov); end
        tests++;
        if (n_pe - p0 !== int'(e_pe)) begin fails++; $display("FAIL parity_err byte %h: got %0d want %0d", b, n_pe - p0, e_pe); end
        if (e_wr) begin
            tests++;
            if (last_din !== b) begin fails++; $display("FAIL din: got %h want %h", last_din, b); end
            tests++;
            if (last_wr_cyc - c0 !== LAT) begin fails++; $display("FAIL wr_latency byte %h: got %0d want %0d", b, last_wr_cyc - c0, LAT); end
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_frame byte %h: got %b want 0", b, busy); end
    endtask

    task automatic drain_fifo(input string tag);
        logic [7:0] got, exp;
        while (fifo_q.size() > 0 && model_q.size() > 0) begin
            got = fifo_q.pop_front();
            exp = model_q.pop_front();
            tests++;
            if (got !== exp) begin fails++; $display("FAIL %s fifo_read: got %h want %h", tag, got, exp); end
        end
        tests++;
        if (fifo_q.size() != 0 || model_q.size() != 0) begin
            fails++; $display("FAIL %s fifo_level: got %0d want %0d", tag, fifo_q.size(), model_q.size());
        end
        fifo_q.delete();
        model_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (wr !== 1'b0)         begin fails++; $display("FAIL reset_wr: got %b want 0", wr); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (din !== 8'h00)       begin fails++; $display("FAIL reset_din: got %h want 00", din); end
        tests++; if (frame_err !== 1'b0)  begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        tests++; if (overrun !== 1'b0)    begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL idle_after_reset: got %b want 0", busy); end
    endtask

    task automatic test_single();
        send_frame(8'hA5, 0, ^8'hA5);
        drain_fifo("single");
    endtask

    task automatic test_glitch();
        int w0, f0, o0, p0;
        w0 = n_wr; f0 = n_fe; o0 = n_ov; p0 = n_pe;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_start_busy: got %b want 1", busy); end
        repeat (30) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b want 0", busy); end
        tests++;
        if (n_wr != w0 || n_fe != f0 || n_ov != o0 || n_pe != p0) begin
            fails++; $display("FAIL glitch_pulses: got wr%0d fe%0d ov%0d pe%0d want none", n_wr - w0, n_fe - f0, n_ov - o0, n_pe - p0);
        end
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 3, ^8'h3C);
        send_frame(8'h5A, 0, ^8'h5A);
        drain_fifo("frame_err");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 17; i++) send_frame(8'(i), 0, ^(8'(i)));
        tests++;
        if (fifo_q.size() != 16) begin fails++; $display("FAIL b2b_level: got %0d want 16", fifo_q.size()); end
        tests++;
        if (consec != 0) begin fails++; $display("FAIL wr_consecutive: got %0d want 0", consec); end
        drain_fifo("b2b");
    endtask

    task automatic test_reset_abort();
        int w0, f0, o0, p0;
        w0 = n_wr; f0 = n_fe; o0 = n_ov; p0 = n_pe;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_mid_frame: got %b want 1", busy); end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0 || din !== 8'h00) begin fails++; $display("FAIL abort_in_reset: got busy %b din %h want 0 00", busy, din); end
        rst_n = 1'b1;
        repeat (8 * CPB) @(negedge clk);
        tests++;
        if (n_wr != w0 || n_fe != f0 || n_ov != o0 || n_pe != p0) begin
            fails++; $display("FAIL abort_pulses: got wr%0d fe%0d ov%0d pe%0d want none", n_wr - w0, n_fe - f0, n_ov - o0, n_pe - p0);
        end
        send_frame(8'h81, 0, ^8'h81);
        drain_fifo("abort");
    endtask

    task automatic test_parity();
        send_frame(8'h07, 0, 1'b1);
        send_frame(8'h07, 0, 1'b0);
        drain_fifo("parity");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int sl;
        bit par;
        for (int n = 0; n < 20; n++) begin
            b   = 8'($urandom);
            sl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            par = ($urandom_range(0, 3) == 0) ? ~^b : ^b;
            send_frame(b, sl, par);
            repeat ($urandom_range(0, 10)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) drain_fifo("random");
        end
        drain_fifo("random_end");
        tests++;
        if (consec != 0) begin fails++; $display("FAIL wr_consecutive_random: got %0d want 0", consec); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_abort();
        if (PAR_EN) test_parity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
